// File: rtl/wb_master_pkg.sv
// wb_master_pkg
//   Shared Wishbone initiator definitions: FSM state encoding, default bus
//   widths and the default ack timeout. Kept in a package so later Wishbone
//   blocks on the same bus can reuse the same encodings and defaults.
package wb_master_pkg;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } wb_state_e;

  // Default bus geometry (6502 address space, byte data).
  localparam int WB_ADDR_W  = 16;
  localparam int WB_DATA_W  = 8;

  // Default maximum number of cycles cyc may stay high without an ack.
  // Legal range 2..255, so an 8-bit timer always suffices.
  localparam int WB_TIMEOUT = 15;
  localparam int WB_TIMER_W = 8;

endpackage

// File: rtl/wb_master.sv
// wb_master
//   Wishbone pipelined-mode initiator. Takes one 8-bit read or write at a
//   time on a valid/ready request port, runs a single Wishbone cycle that
//   honours stall and ack, and returns read data or a timeout error on a
//   one-cycle response strobe. Every output is registered.
//
// Ports
//   i_clk, reset            clock, synchronous active-high reset
//   i_req_valid/we/addr/data request port, accepted when valid && ready
//   o_req_ready             high while idle
//   o_rsp_valid/data/err    one-cycle response (data 0 for writes/errors)
//   o_wb_cyc/stb/we/addr/data  Wishbone initiator outputs
//   i_wb_ack/stall/data     Wishbone slave inputs
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no cycle open, o_req_ready=1, waiting for a request
// ST_REQ  | cyc=stb=1, holding the request until the slave stops stalling
// ST_WAIT | cyc=1, stb=0, request taken by the slave, waiting for ack
module wb_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DATA_W-1:0] i_wb_data
);

  // The timer is a down-counter loaded with TIMEOUT-1 in the first cyc
  // cycle; reaching zero marks the last cycle cyc may stay high.
  localparam logic [WB_TIMER_W-1:0] TIMER_LOAD = WB_TIMER_W'(TIMEOUT - 1);

  wb_state_e             state_q;
  logic [WB_TIMER_W-1:0] timer_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  rsp_err_q;
  logic                  cyc_q;
  logic                  stb_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;

  logic                  ack_take;
  logic                  tmo_hit;

  // An ack only counts once the slave has taken stb: in WAIT, or in REQ
  // during the cycle the slave stops stalling. Acks anywhere else are a
  // slave protocol error and are dropped. An ack in the final timer cycle
  // beats the timeout.
  always_comb begin
    ack_take = 1'b0;
    tmo_hit  = 1'b0;
    if (state_q == ST_WAIT) begin
      ack_take = i_wb_ack;
    end else if (state_q == ST_REQ) begin
      ack_take = i_wb_ack && !i_wb_stall;
    end
    if (state_q != ST_IDLE) begin
      tmo_hit = (timer_q == '0) && !ack_take;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      // Response fields are only non-zero during the strobe cycle.
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            we_q        <= i_req_we;
            addr_q      <= i_req_addr;
            data_q      <= i_req_we ? i_req_data : '0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            req_ready_q <= 1'b0;
            timer_q     <= TIMER_LOAD;
            state_q     <= ST_REQ;
          end
        end

        ST_REQ, ST_WAIT: begin
          if (ack_take) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= we_q ? '0 : i_wb_data;
            state_q     <= ST_IDLE;
          end else if (tmo_hit) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            timer_q <= timer_q - WB_TIMER_W'(1);
            if ((state_q == ST_REQ) && !i_wb_stall) begin
              stb_q   <= 1'b0;
              state_q <= ST_WAIT;
            end
          end
        end

        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master
//   Directed bench for wb_master. Stimulus pushes the expected bus request
//   and the expected response (with its cycle number relative to the accept
//   cycle) into queues; independent monitors pop and compare whenever the
//   DUT opens a bus cycle or strobes a response. A configurable slave model
//   supplies stall, ack delay, missing ack and stray acks.
module tb_wb_master;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_we = 1'b0;
  logic [15:0] i_req_addr = '0;
  logic [7:0]  i_req_data = '0;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic        o_rsp_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [15:0] o_wb_addr;
  logic [7:0]  o_wb_data;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic [7:0]  i_wb_data = '0;

  always #5 clk = ~clk;

  wb_master #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .reset       (rst),
    .i_req_valid (i_req_valid),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .i_wb_ack    (i_wb_ack),
    .i_wb_stall  (i_wb_stall),
    .i_wb_data   (i_wb_data)
  );

  // cnt increments on every rising edge; at the falling edge of cycle k
  // after an accept recorded as acc, cnt == acc + k.
  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {int cyc; logic err; logic [7:0] data;} rsp_t;
  typedef struct {logic we; logic [15:0] addr; logic [7:0] data;} bus_t;
  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // ---------------- response monitor ----------------
  int   rsp_seen = 0;
  logic prev_rsp = 1'b0;
  rsp_t er;
  always @(negedge clk) begin
    if (o_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0d data=0x%0h, expected no response (t=%0t)",
                 o_rsp_err, o_rsp_data, $time);
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_cycle", cnt, er.cyc);
        chk("rsp_err", o_rsp_err, er.err);
        chk("rsp_data", o_rsp_data, er.data);
        chk("ready_with_rsp", o_req_ready, 1'b1);
        chk("rsp_pulse_width", prev_rsp, 1'b0);
      end
      rsp_seen++;
    end
    prev_rsp = o_rsp_valid;
  end

  // ---------------- bus monitor ----------------
  logic prev_cyc = 1'b0;
  bus_t cur;
  int   stb_cnt = 0;
  int   cyc_cnt = 0;
  int   stb_cycles[$];
  always @(negedge clk) begin
    if (o_wb_stb) chk("stb_implies_cyc", o_wb_cyc, 1'b1);
    if (o_wb_cyc) begin
      cyc_cnt++;
      if (o_wb_stb) begin
        stb_cnt++;
        stb_cycles.push_back(cnt);
      end
      if (!prev_cyc) begin
        if (bus_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_cyc: got cyc=1 addr=0x%0h, expected idle bus (t=%0t)", o_wb_addr, $time);
          cur.we = o_wb_we; cur.addr = o_wb_addr; cur.data = o_wb_data;
        end else begin
          cur = bus_q.pop_front();
          chk("bus_we", o_wb_we, cur.we);
          chk("bus_addr", o_wb_addr, cur.addr);
          chk("bus_wdata", o_wb_data, cur.data);
        end
      end else begin
        chk("bus_we_stable", o_wb_we, cur.we);
        chk("bus_addr_stable", o_wb_addr, cur.addr);
        chk("bus_wdata_stable", o_wb_data, cur.data);
      end
    end
    prev_cyc = o_wb_cyc;
  end

  // ---------------- slave model ----------------
  int         cfg_stall = 0;
  int         cfg_gap   = 1;
  bit         cfg_noack = 1'b0;
  bit         cfg_stray = 1'b0;
  logic [7:0] cfg_rdata = '0;
  int         stall_left = 0;
  int         wait_left  = 0;
  bit         armed      = 1'b0;
  always @(negedge clk) begin
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = '0;
    if (!o_wb_cyc) begin
      stall_left = cfg_stall;
      armed      = 1'b0;
      if (cfg_stray) begin
        i_wb_ack  = 1'b1;
        i_wb_data = 8'hEE;
      end
    end else if (o_wb_stb) begin
      if (stall_left > 0) begin
        i_wb_stall = 1'b1;
        stall_left--;
        if (cfg_stray) i_wb_ack = 1'b1;
      end else begin
        armed     = 1'b1;
        wait_left = cfg_gap;
        if (cfg_gap == 0 && !cfg_noack) begin
          i_wb_ack  = 1'b1;
          i_wb_data = cfg_rdata;
        end
      end
    end else if (armed && !cfg_noack) begin
      wait_left--;
      if (wait_left == 0) begin
        i_wb_ack  = 1'b1;
        i_wb_data = cfg_rdata;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int g;
    g = 0;
    @(negedge clk);
    while (!o_req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!o_req_ready) chk("ready_wait_expired", o_req_ready, 1'b1);
  endtask

  task automatic xact(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                      input int stall, input int gap, input bit noack, input logic [7:0] rd,
                      input logic exp_err, input logic [7:0] exp_data,
                      input int exp_lat, input int exp_stb, input int exp_cyc);
    int   acc;
    int   g;
    bus_t b;
    rsp_t r;
    cfg_stall = stall;
    cfg_gap   = gap;
    cfg_noack = noack;
    cfg_rdata = rd;
    wait_ready();
    stb_cnt  = 0;
    cyc_cnt  = 0;
    rsp_seen = 0;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_data  = wd;
    acc = cnt;
    b.we = we; b.addr = addr; b.data = we ? wd : 8'h00;
    bus_q.push_back(b);
    r.cyc = acc + exp_lat; r.err = exp_err; r.data = exp_data;
    rsp_q.push_back(r);
    @(negedge clk);
    // Scramble request inputs so any leak onto the bus is visible.
    i_req_valid = 1'b0;
    i_req_we    = ~we;
    i_req_addr  = ~addr;
    i_req_data  = ~wd;
    g = 0;
    while (rsp_seen == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("rsp_arrived", rsp_seen, 1);
    chk("stb_cycles", stb_cnt, exp_stb);
    chk("cyc_cycles", cyc_cnt, exp_cyc);
  endtask

  initial begin : main
    int   acc;
    int   g;
    bus_t b;
    rsp_t r;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_req_ready, 1'b1);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rsp_data", o_rsp_data, 8'h00);
    chk("rst_rsp_err", o_rsp_err, 1'b0);
    chk("rst_cyc", o_wb_cyc, 1'b0);
    chk("rst_stb", o_wb_stb, 1'b0);
    chk("rst_wb_addr", o_wb_addr, 16'h0000);
    rst = 1'b0;

    //    we  addr     wdata  stall gap noack rdata  err  data   lat stb cyc
    // Basic write and read, zero stall, ack one cycle after stb.
    xact(1, 16'h0080, 8'h5A, 0,    1,  0,    8'h99, 0,   8'h00, 3,  1,  2);
    xact(0, 16'h0083, 8'hFF, 0,    1,  0,    8'h3C, 0,   8'h3C, 3,  1,  2);
    // Stall held 4 cycles; ack lands in the second cycle after stb drops.
    xact(0, 16'h1234, 8'h00, 4,    2,  0,    8'hA7, 0,   8'hA7, 8,  5,  7);
    // Ack in the same cycle stall releases completes straight from REQ.
    xact(0, 16'hBEEF, 8'h00, 2,    0,  0,    8'h42, 0,   8'h42, 4,  3,  3);
    // No ack: cyc high cycles 1..15, error at 16.
    xact(0, 16'h0200, 8'h00, 0,    1,  1,    8'h55, 1,   8'h00, 16, 1,  15);
    // Ack exactly on cycle 15 beats the timeout.
    xact(0, 16'h0201, 8'h00, 0,    14, 0,    8'hA5, 0,   8'hA5, 16, 1,  15);
    // Slave stalls forever: timeout with stb held the whole time.
    xact(1, 16'h0300, 8'h77, 100,  1,  0,    8'h00, 1,   8'h00, 16, 15, 15);

    // Stray acks in idle and during stall are ignored.
    cfg_stray = 1'b1;
    xact(1, 16'h4000, 8'hC3, 3,    1,  0,    8'h00, 0,   8'h00, 6,  4,  5);
    rsp_seen = 0;
    repeat (5) @(negedge clk);
    chk("stray_ack_no_rsp", rsp_seen, 0);
    chk("stray_ack_ready", o_req_ready, 1'b1);
    cfg_stray = 1'b0;

    // Reset asserted while waiting for ack.
    cfg_stall = 0; cfg_gap = 1; cfg_noack = 1'b1;
    wait_ready();
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 16'h0500; i_req_data = 8'h00;
    b.we = 1'b0; b.addr = 16'h0500; b.data = 8'h00;
    bus_q.push_back(b);
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", o_wb_cyc, 1'b1);
    chk("pre_rst_stb", o_wb_stb, 1'b0);
    rsp_seen = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cyc", o_wb_cyc, 1'b0);
    chk("mid_rst_stb", o_wb_stb, 1'b0);
    chk("mid_rst_ready", o_req_ready, 1'b1);
    chk("mid_rst_rsp_valid", o_rsp_valid, 1'b0);
    repeat (TO + 4) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_seen, 0);
    cfg_noack = 1'b0;

    // Back-to-back with valid held high: accepts at cycles 0 and 3.
    cfg_stall = 0; cfg_gap = 1; cfg_rdata = 8'h77;
    wait_ready();
    stb_cycles.delete();
    rsp_seen = 0;
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 16'h0010; i_req_data = 8'h11;
    acc = cnt;
    b.we = 1'b1; b.addr = 16'h0010; b.data = 8'h11; bus_q.push_back(b);
    b.we = 1'b0; b.addr = 16'h0011; b.data = 8'h00; bus_q.push_back(b);
    r.cyc = acc + 3; r.err = 1'b0; r.data = 8'h00; rsp_q.push_back(r);
    r.cyc = acc + 6; r.err = 1'b0; r.data = 8'h77; rsp_q.push_back(r);
    @(negedge clk);
    i_req_we = 1'b0; i_req_addr = 16'h0011; i_req_data = 8'h22;
    repeat (3) @(negedge clk);
    i_req_valid = 1'b0;
    g = 0;
    while (rsp_seen < 2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("b2b_rsp_count", rsp_seen, 2);
    chk("b2b_stb_count", stb_cycles.size(), 2);
    if (stb_cycles.size() == 2) begin
      chk("b2b_stb_first", stb_cycles[0], acc + 1);
      chk("b2b_stb_second", stb_cycles[1], acc + 4);
    end

    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
